// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - MIPS opcode values and instruction field positions
package mips_pkg;

  localparam int OP_WIDTH = 6;

  localparam int IMM_LSB = 0;
  localparam int IMM_MSB = 15;
  localparam int OP_LSB  = 26;
  localparam int OP_MSB  = 31;

  localparam logic [OP_WIDTH-1:0] OP_RTYPE  = 6'h00;
  localparam logic [OP_WIDTH-1:0] OP_REGIMM = 6'h01;
  localparam logic [OP_WIDTH-1:0] OP_J      = 6'h02;
  localparam logic [OP_WIDTH-1:0] OP_JAL    = 6'h03;
  localparam logic [OP_WIDTH-1:0] OP_BEQ    = 6'h04;
  localparam logic [OP_WIDTH-1:0] OP_BNE    = 6'h05;
  localparam logic [OP_WIDTH-1:0] OP_BLEZ   = 6'h06;
  localparam logic [OP_WIDTH-1:0] OP_BGTZ   = 6'h07;
  localparam logic [OP_WIDTH-1:0] OP_ADDI   = 6'h08;
  localparam logic [OP_WIDTH-1:0] OP_ADDIU  = 6'h09;
  localparam logic [OP_WIDTH-1:0] OP_SLTI   = 6'h0A;
  localparam logic [OP_WIDTH-1:0] OP_SLTIU  = 6'h0B;
  localparam logic [OP_WIDTH-1:0] OP_ANDI   = 6'h0C;
  localparam logic [OP_WIDTH-1:0] OP_ORI    = 6'h0D;
  localparam logic [OP_WIDTH-1:0] OP_XORI   = 6'h0E;
  localparam logic [OP_WIDTH-1:0] OP_LUI    = 6'h0F;
  localparam logic [OP_WIDTH-1:0] OP_LB     = 6'h20;
  localparam logic [OP_WIDTH-1:0] OP_LW     = 6'h23;
  localparam logic [OP_WIDTH-1:0] OP_SB     = 6'h28;
  localparam logic [OP_WIDTH-1:0] OP_SW     = 6'h2B;
  localparam logic [OP_WIDTH-1:0] OP_SWR    = 6'h2E;

endpackage

// File: rtl/if_id_stage_if.sv
// rtl/if_id_stage_if.sv - fetch-side and decode-side handshake bundle of the IF/ID register
interface if_id_stage_if #(
  parameter int INSTR_WIDTH = 32,
  parameter int IMM_WIDTH   = 16,
  parameter int PC_WIDTH    = 32,
  parameter int DEPTH       = 2
);
  logic                         in_valid;
  logic                         in_ready;
  logic [INSTR_WIDTH*DEPTH-1:0] in_instr;
  logic [PC_WIDTH-1:0]          in_pc;
  logic [DEPTH-1:0]             in_lane_valid;
  logic                         flush;
  logic                         out_valid;
  logic                         out_ready;
  logic [INSTR_WIDTH*DEPTH-1:0] out_instr;
  logic [PC_WIDTH-1:0]          out_pc;
  logic [DEPTH-1:0]             out_lane_valid;
  logic [IMM_WIDTH*DEPTH-1:0]   out_imm;
  logic [DEPTH-1:0]             out_is_signed;
  logic [DEPTH-1:0]             out_load_upper;

  modport slave (
    input  in_valid, in_instr, in_pc, in_lane_valid, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_lane_valid,
           out_imm, out_is_signed, out_load_upper
  );

  modport master (
    output in_valid, in_instr, in_pc, in_lane_valid, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_lane_valid,
           out_imm, out_is_signed, out_load_upper
  );
endinterface

// File: rtl/if_id_stage_imm_predecode.sv
// rtl/if_id_stage_imm_predecode.sv - single-lane immediate field and extender-control pre-decode
module imm_predecode
  import mips_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int IMM_WIDTH   = 16
) (
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic                   lane_valid,
  output logic [IMM_WIDTH-1:0]   imm,
  output logic                   is_signed,
  output logic                   load_upper
);
  logic [OP_WIDTH-1:0] opcode;
  logic                unused_mid_bits;

  assign opcode          = instr[OP_MSB:OP_LSB];
  assign unused_mid_bits = ^instr[OP_LSB-1:IMM_LSB+IMM_WIDTH];

  always_comb begin
    imm        = '0;
    is_signed  = 1'b0;
    load_upper = 1'b0;
    if (lane_valid) begin
      imm = instr[IMM_LSB +: IMM_WIDTH];
      // Arithmetic immediates, memory offsets and branch displacements sign-extend.
      if (opcode inside {OP_REGIMM, [OP_BEQ:OP_BGTZ], [OP_ADDI:OP_SLTIU], [OP_LB:OP_SWR]}) begin
        is_signed = 1'b1;
      end else if (opcode == OP_LUI) begin
        load_upper = 1'b1;
      end
    end
  end
endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID pipeline register with 2-entry skid, flush and immediate pre-decode
module if_id_stage
  import mips_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int IMM_WIDTH   = 16,
  parameter int PC_WIDTH    = 32,
  parameter int DEPTH       = 2
) (
  input logic            clk,
  input logic            rst,
  if_id_stage_if.slave   io
);
  localparam int IW = INSTR_WIDTH * DEPTH;
  localparam int MW = IMM_WIDTH * DEPTH;

  typedef struct packed {
    logic [IW-1:0]       instr;
    logic [PC_WIDTH-1:0] pc;
    logic [DEPTH-1:0]    lane_valid;
    logic [MW-1:0]       imm;
    logic [DEPTH-1:0]    is_signed;
    logic [DEPTH-1:0]    load_upper;
  } bundle_t;

  bundle_t          in_bundle;
  bundle_t          main_d, main_q, skid_d, skid_q;
  logic             main_valid_d, main_valid_q;
  logic             skid_valid_d, skid_valid_q;
  logic             in_ready_d, in_ready_q;
  logic [MW-1:0]    pre_imm;
  logic [DEPTH-1:0] pre_signed, pre_upper;
  logic             accept, drain;

  for (genvar g = 0; g < DEPTH; g++) begin : g_lane
    imm_predecode #(
      .INSTR_WIDTH (INSTR_WIDTH),
      .IMM_WIDTH   (IMM_WIDTH)
    ) u_predecode (
      .instr      (io.in_instr[INSTR_WIDTH*g +: INSTR_WIDTH]),
      .lane_valid (io.in_lane_valid[g]),
      .imm        (pre_imm[IMM_WIDTH*g +: IMM_WIDTH]),
      .is_signed  (pre_signed[g]),
      .load_upper (pre_upper[g])
    );
  end

  assign in_bundle = '{instr: io.in_instr, pc: io.in_pc, lane_valid: io.in_lane_valid,
                       imm: pre_imm, is_signed: pre_signed, load_upper: pre_upper};

  // in_ready is a flop so fetch never sees a path from decode's out_ready.
  assign io.in_ready = in_ready_q & rst;
  assign accept      = io.in_valid & io.in_ready;
  assign drain       = main_valid_q & io.out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (io.flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (drain) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q || drain) begin
        main_d       = in_bundle;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = in_bundle;
        skid_valid_d = 1'b1;
      end
    end else if (drain) begin
      main_valid_d = 1'b0;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign io.out_valid      = main_valid_q;
  assign io.out_instr      = main_q.instr;
  assign io.out_pc         = main_q.pc;
  assign io.out_lane_valid = main_q.lane_valid;
  assign io.out_imm        = main_q.imm;
  assign io.out_is_signed  = main_q.is_signed;
  assign io.out_load_upper = main_q.load_upper;
endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - directed scoreboard bench for if_id_stage
module tb_if_id_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  if_id_stage_if bus ();

  if_id_stage dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  typedef struct {
    logic [63:0] instr;
    logic [31:0] pc;
    logic [1:0]  lv;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // returns {load_upper, is_signed} for one opcode
  function automatic logic [1:0] ref_ctl(input logic [5:0] op);
    if (op == 6'h0F) return 2'b10;
    if (op == 6'h01) return 2'b01;
    if (op >= 6'h04 && op <= 6'h0B) return 2'b01;
    if (op >= 6'h20 && op <= 6'h2E) return 2'b01;
    return 2'b00;
  endfunction

  task automatic drive(input logic v, input logic [63:0] instr, input logic [31:0] pc,
                       input logic [1:0] lv);
    bus.in_valid      = v;
    bus.in_instr      = instr;
    bus.in_pc         = pc;
    bus.in_lane_valid = lv;
  endtask

  task automatic tick();
    exp_t        e;
    logic        acc, drn;
    logic [31:0] ximm;
    logic [1:0]  xsg, xlu, c;
    @(negedge clk);
    if (!rst) begin
      chk("in_ready_in_reset", {63'd0, bus.in_ready}, 64'd0);
      sb.delete();
    end else begin
      chk("out_valid_model", {63'd0, bus.out_valid}, {63'd0, sb.size() != 0});
      chk("in_ready_model", {63'd0, bus.in_ready}, {63'd0, sb.size() < 2});
      acc = bus.in_valid && bus.in_ready;
      drn = bus.out_valid && bus.out_ready;
      if (drn) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", {63'd0, bus.out_valid}, 64'd0);
        end else begin
          e = sb.pop_front();
          for (int l = 0; l < 2; l++) begin
            c = ref_ctl(e.instr[32*l+26 +: 6]);
            ximm[16*l +: 16] = e.lv[l] ? e.instr[32*l +: 16] : 16'h0;
            xsg[l] = e.lv[l] & c[0];
            xlu[l] = e.lv[l] & c[1];
          end
          chk("out_instr", bus.out_instr, e.instr);
          chk("out_pc", {32'd0, bus.out_pc}, {32'd0, e.pc});
          chk("out_lane_valid", {62'd0, bus.out_lane_valid}, {62'd0, e.lv});
          chk("out_imm", {32'd0, bus.out_imm}, {32'd0, ximm});
          chk("out_is_signed", {62'd0, bus.out_is_signed}, {62'd0, xsg});
          chk("out_load_upper", {62'd0, bus.out_load_upper}, {62'd0, xlu});
        end
      end
      if (bus.flush) sb.delete();
      else if (acc) sb.push_back('{instr: bus.in_instr, pc: bus.in_pc, lv: bus.in_lane_valid});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain_all();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10 && sb.size() != 0; k++) tick();
    chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, {63'd0, bus.out_valid}, 64'd0);
    chk({tag, "_out_instr"}, bus.out_instr, 64'd0);
    chk({tag, "_out_pc"}, {32'd0, bus.out_pc}, 64'd0);
    chk({tag, "_out_lv"}, {62'd0, bus.out_lane_valid}, 64'd0);
    chk({tag, "_out_imm"}, {32'd0, bus.out_imm}, 64'd0);
    chk({tag, "_out_sg"}, {62'd0, bus.out_is_signed}, 64'd0);
    chk({tag, "_out_lu"}, {62'd0, bus.out_load_upper}, 64'd0);
  endtask

  initial begin
    logic [31:0] r0, r1, r2;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 64'd0, 32'd0, 2'b00);
    #1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk_all_zero("reset");
    chk("in_ready_after_reset", {63'd0, bus.in_ready}, 64'd1);

    // single ADDI/LUI bundle
    bus.out_ready = 1'b1;
    drive(1'b1, {32'h3C011234, 32'h2008FFFF}, 32'h0000_1000, 2'b11);
    tick();
    drive(1'b0, 64'd0, 32'd0, 2'b00);
    chk("t1_out_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("t1_out_imm", {32'd0, bus.out_imm}, 64'h1234FFFF);
    chk("t1_out_is_signed", {62'd0, bus.out_is_signed}, 64'd1);
    chk("t1_out_load_upper", {62'd0, bus.out_load_upper}, 64'd2);
    tick();

    // backpressure: A main, B skid, C held
    bus.out_ready = 1'b0;
    drive(1'b1, {32'h2402AAAA, 32'h2401000A}, 32'h0000_2000, 2'b11);
    tick();
    drive(1'b1, {32'h3403BBBB, 32'h8C04000B}, 32'h0000_2008, 2'b11);
    tick();
    drive(1'b1, {32'h3C05CCCC, 32'hAC06000C}, 32'h0000_2010, 2'b11);
    tick();
    tick();
    chk("bp_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
    bus.out_ready = 1'b1;
    tick();
    tick();
    drive(1'b0, 64'd0, 32'd0, 2'b00);
    drain_all();

    // invalid upper lane
    drive(1'b1, {32'h3421ABCD, 32'h8C221234}, 32'h0000_3000, 2'b01);
    tick();
    drive(1'b0, 64'd0, 32'd0, 2'b00);
    chk("inv_imm_hi", {48'd0, bus.out_imm[31:16]}, 64'd0);
    chk("inv_sg_hi", {63'd0, bus.out_is_signed[1]}, 64'd0);
    chk("inv_lu_hi", {63'd0, bus.out_load_upper[1]}, 64'd0);
    tick();

    // flush with both slots full and a bundle offered
    bus.out_ready = 1'b0;
    drive(1'b1, {32'h20110001, 32'h20100000}, 32'h0000_4000, 2'b11);
    tick();
    drive(1'b1, {32'h20130003, 32'h20120002}, 32'h0000_4008, 2'b11);
    tick();
    drive(1'b1, {32'h20150005, 32'h20140004}, 32'h0000_4010, 2'b11);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 64'd0, 32'd0, 2'b00);
    chk("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, bus.in_ready}, 64'd1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();

    // reset mid-stream with both slots full
    bus.out_ready = 1'b0;
    drive(1'b1, {32'h3C17DEAD, 32'h2016BEEF}, 32'h0000_5000, 2'b11);
    tick();
    drive(1'b1, {32'h3018F00D, 32'h2819CAFE}, 32'h0000_5008, 2'b10);
    tick();
    drive(1'b0, 64'd0, 32'd0, 2'b00);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    chk("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    bus.out_ready = 1'b1;
    drive(1'b1, {32'h00000000, 32'h24010077}, 32'h0000_6000, 2'b01);
    tick();
    drive(1'b0, 64'd0, 32'd0, 2'b00);
    chk("midrst_first_out", {63'd0, bus.out_valid}, 64'd1);
    tick();

    // opcode sweep on lane 0, streaming
    bus.out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      r0 = $urandom();
      r1 = $urandom();
      r2 = $urandom();
      r2[0] = 1'b1;
      drive(1'b1, {r1, 6'(i), r0[25:0]}, 32'h0001_0000 + 32'(i * 8), r2[1:0]);
      tick();
    end
    drain_all();

    // R-type
    r1 = $urandom();
    drive(1'b1, {r1, 32'h012A4020}, 32'h0002_0000, 2'b01);
    tick();
    drive(1'b0, 64'd0, 32'd0, 2'b00);
    chk("rtype_imm", {48'd0, bus.out_imm[15:0]}, 64'h4020);
    chk("rtype_sg", {63'd0, bus.out_is_signed[0]}, 64'd0);
    chk("rtype_lu", {63'd0, bus.out_load_upper[0]}, 64'd0);
    tick();
    drain_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
